// File: rtl/back_ctrl_pipe_if.sv
// back_ctrl_pipe_if: token input/output handshake bundle plus request and status outputs
interface back_ctrl_pipe_if #(
   parameter int RN_W = 9,
   parameter int AW   = 7
);
   logic            in_valid;
   logic            in_ready;
   logic [RN_W-1:0] in_read_num;
   logic [5:0]      in_status;
   logic [AW-1:0]   in_rd_addr;
   logic [AW-1:0]   in_wr_addr;
   logic [AW-1:0]   in_mem_size;
   logic [63:0]     in_bk;
   logic [63:0]     in_bl;
   logic            out_valid;
   logic            out_ready;
   logic [RN_W-1:0] out_read_num;
   logic [5:0]      out_status;
   logic [AW-1:0]   out_rd_addr;
   logic [AW-1:0]   out_wr_addr;
   logic [AW-1:0]   out_mem_size;
   logic [63:0]     out_bk;
   logic [63:0]     out_bl;
   logic            request_valid;
   logic [41:0]     addr_k;
   logic [41:0]     addr_l;
   logic            finish_sign;
   logic [3:0]      in_flight;
   logic [15:0]     fin_count;
   modport master (
      output in_valid, in_read_num, in_status, in_rd_addr, in_wr_addr, in_mem_size, in_bk, in_bl, out_ready,
      input  in_ready, out_valid, out_read_num, out_status, out_rd_addr, out_wr_addr, out_mem_size, out_bk, out_bl,
      input  request_valid, addr_k, addr_l, finish_sign, in_flight, fin_count
   );
   modport slave (
      input  in_valid, in_read_num, in_status, in_rd_addr, in_wr_addr, in_mem_size, in_bk, in_bl, out_ready,
      output in_ready, out_valid, out_read_num, out_status, out_rd_addr, out_wr_addr, out_mem_size, out_bk, out_bl,
      output request_valid, addr_k, addr_l, finish_sign, in_flight, fin_count
   );
endinterface

// File: rtl/back_ctrl_pipe.sv
// back_ctrl_pipe: DEPTH-stage elastic token pipeline with bubble collapse,
// memory-request strobe on ST_BWD tokens and completion counting on ST_FIN tokens.
module back_ctrl_pipe #(
   parameter int         DEPTH  = 3,
   parameter int         RN_W   = 9,
   parameter int         AW     = 7,
   parameter logic [5:0] ST_BWD = 6'd3,
   parameter logic [5:0] ST_FIN = 6'd63
) (
   input  logic clk,
   input  logic rst,
   input  logic stall,
   input  logic flush,
   back_ctrl_pipe_if.slave bus
);
   typedef struct packed {
      logic [RN_W-1:0] read_num;
      logic [5:0]      status;
      logic [AW-1:0]   rd_addr;
      logic [AW-1:0]   wr_addr;
      logic [AW-1:0]   mem_size;
      logic [63:0]     bk;
      logic [63:0]     bl;
   } tok_t;
   tok_t             st_q [DEPTH];
   tok_t             st_d [DEPTH];
   tok_t             in_tok;
   tok_t             out_tok;
   logic [DEPTH-1:0] v_q, v_d, ld;
   logic             go, in_hs, out_hs, out_v;
   logic [3:0]       in_flight_q, in_flight_d;
   logic [15:0]      fin_count_q, fin_count_d;
   always_comb begin
      go = !stall && !flush;
      // a stage moves when any stage from it to the tail has a hole, or the tail drains
      for (int s = 0; s < DEPTH; s++)
         ld[s] = go && (bus.out_ready || !(&(v_q | DEPTH'((1 << s) - 1))));
      in_tok.read_num = bus.in_read_num;
      in_tok.status   = bus.in_status;
      in_tok.rd_addr  = bus.in_rd_addr;
      in_tok.wr_addr  = bus.in_wr_addr;
      in_tok.mem_size = bus.in_mem_size;
      in_tok.bk       = bus.in_bk;
      in_tok.bl       = bus.in_bl;
      out_tok = st_q[DEPTH-1];
      out_v   = v_q[DEPTH-1];
      in_hs   = rst && bus.in_valid && ld[0];
      out_hs  = out_v && bus.out_ready && go;
      v_d[0]  = flush ? 1'b0 : (ld[0] ? bus.in_valid : v_q[0]);
      st_d[0] = ld[0] ? in_tok : st_q[0];
      for (int s = 1; s < DEPTH; s++) begin
         v_d[s]  = flush ? 1'b0 : (ld[s] ? v_q[s-1] : v_q[s]);
         st_d[s] = ld[s] ? st_q[s-1] : st_q[s];
      end
      in_flight_d = flush ? 4'd0 : in_flight_q + {3'd0, in_hs} - {3'd0, out_hs};
      fin_count_d = fin_count_q + {15'd0, out_hs && out_tok.status == ST_FIN};
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         v_q         <= '0;
         for (int s = 0; s < DEPTH; s++) st_q[s] <= '0;
         in_flight_q <= '0;
         fin_count_q <= '0;
      end else begin
         v_q         <= v_d;
         st_q        <= st_d;
         in_flight_q <= in_flight_d;
         fin_count_q <= fin_count_d;
      end
   end
   assign bus.in_ready      = rst && ld[0];
   assign bus.out_valid     = out_v;
   assign bus.out_read_num  = out_tok.read_num;
   assign bus.out_status    = out_tok.status;
   assign bus.out_rd_addr   = out_tok.rd_addr;
   assign bus.out_wr_addr   = out_tok.wr_addr;
   assign bus.out_mem_size  = out_tok.mem_size;
   assign bus.out_bk        = out_tok.bk;
   assign bus.out_bl        = out_tok.bl;
   assign bus.addr_k        = out_v ? out_tok.bk[47:6] : '0;
   assign bus.addr_l        = out_v ? out_tok.bl[47:6] : '0;
   assign bus.request_valid = rst && out_hs && out_tok.status == ST_BWD;
   assign bus.finish_sign   = rst && out_v && out_tok.status == ST_FIN;
   assign bus.in_flight     = in_flight_q;
   assign bus.fin_count     = fin_count_q;
endmodule

// File: tb/tb_back_ctrl_pipe.sv
// tb_back_ctrl_pipe: directed and randomized checks of back_ctrl_pipe against a
// queue model where each token carries its stage position and advances up to the token ahead.
module tb_back_ctrl_pipe;
   localparam int         DEPTH  = 3;
   localparam int         RN_W   = 9;
   localparam int         AW     = 7;
   localparam logic [5:0] ST_BWD = 6'd3;
   localparam logic [5:0] ST_FIN = 6'd63;

   typedef struct {
      logic [RN_W-1:0] rn;
      logic [5:0]      st;
      logic [AW-1:0]   ra, wa, ms;
      logic [63:0]     bk, bl;
      int              pos;
   } ent_t;

   logic clk = 0, rst = 0, stall = 0, flush = 0;
   int   errors = 0, checks = 0, cyc = 0;
   bit   chk_on = 0, fs_seen = 0;
   ent_t q[$];
   logic [15:0] m_fin = 0;
   logic [RN_W-1:0] outs[$];
   int   hs_n = 0, hs_first = 0, out_first = 0, out_last = 0, req_n = 0;
   logic [41:0] req_k = 0, req_l = 0;

   back_ctrl_pipe_if #(.RN_W(RN_W), .AW(AW)) bus ();
   back_ctrl_pipe #(.DEPTH(DEPTH), .RN_W(RN_W), .AW(AW), .ST_BWD(ST_BWD), .ST_FIN(ST_FIN)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // position token i will hold after the next advancing edge; DEPTH means it has left
   function automatic int next_pos(int i);
      int prev, p;
      prev = bus.out_ready ? DEPTH + 1 : DEPTH;
      p = 0;
      for (int k = 0; k <= i; k++) begin
         p = (q[k].pos + 1 < prev - 1) ? q[k].pos + 1 : prev - 1;
         prev = p;
      end
      return p;
   endfunction

   function automatic bit exp_in_ready();
      return rst && !stall && !flush && (q.size() == 0 || next_pos(q.size() - 1) > 0);
   endfunction

   function automatic bit exp_ov();
      return q.size() > 0 && q[0].pos == DEPTH - 1;
   endfunction

   always @(posedge clk) begin
      int np[$];
      bit acc;
      cyc++;
      np.delete();
      acc = exp_in_ready();
      if (!rst) begin
         q.delete();
         m_fin = 0;
      end else if (flush) begin
         q.delete();
      end else if (!stall) begin
         foreach (q[k]) np.push_back(next_pos(k));
         foreach (q[k]) q[k].pos = np[k];
         if (q.size() > 0 && q[0].pos == DEPTH) begin
            if (q[0].st == ST_FIN) m_fin++;
            void'(q.pop_front());
         end
         if (bus.in_valid && acc)
            q.push_back('{rn: bus.in_read_num, st: bus.in_status, ra: bus.in_rd_addr, wa: bus.in_wr_addr,
                          ms: bus.in_mem_size, bk: bus.in_bk, bl: bus.in_bl, pos: 0});
      end
   end

   always @(negedge clk) begin
      ent_t hd;
      bit ov;
      ov = exp_ov();
      hd = '{rn: '0, st: '0, ra: '0, wa: '0, ms: '0, bk: '0, bl: '0, pos: 0};
      if (ov) hd = q[0];
      if (chk_on) begin
         chk("in_ready", bus.in_ready, exp_in_ready());
         chk("out_valid", bus.out_valid, ov);
         chk("in_flight", bus.in_flight, q.size());
         chk("fin_count", bus.fin_count, m_fin);
         chk("finish_sign", bus.finish_sign, rst && ov && hd.st == ST_FIN);
         chk("request_valid", bus.request_valid,
             rst && ov && bus.out_ready && !stall && !flush && hd.st == ST_BWD);
         chk("addr_k", bus.addr_k, ov ? hd.bk[47:6] : 42'd0);
         chk("addr_l", bus.addr_l, ov ? hd.bl[47:6] : 42'd0);
         if (ov) begin
            chk("out_read_num", bus.out_read_num, hd.rn);
            chk("out_status", bus.out_status, hd.st);
            chk("out_rd_addr", bus.out_rd_addr, hd.ra);
            chk("out_wr_addr", bus.out_wr_addr, hd.wa);
            chk("out_mem_size", bus.out_mem_size, hd.ms);
            chk("out_bk", bus.out_bk, hd.bk);
            chk("out_bl", bus.out_bl, hd.bl);
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         if (hs_n == 0) hs_first = cyc;
         hs_n++;
      end
      if (rst && bus.out_valid && bus.out_ready && !stall && !flush) begin
         if (outs.size() == 0) out_first = cyc;
         out_last = cyc;
         outs.push_back(bus.out_read_num);
      end
      if (bus.request_valid) begin
         req_n++;
         req_k = bus.addr_k;
         req_l = bus.addr_l;
      end
      if (bus.finish_sign) fs_seen = 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      outs.delete();
      hs_n = 0;
      req_n = 0;
      fs_seen = 0;
   endtask

   task automatic drive_tok(logic [RN_W-1:0] rn, logic [5:0] st, logic [63:0] bk, logic [63:0] bl);
      bus.in_read_num = rn;
      bus.in_status   = st;
      bus.in_rd_addr  = AW'($urandom);
      bus.in_wr_addr  = AW'($urandom);
      bus.in_mem_size = AW'($urandom);
      bus.in_bk       = bk;
      bus.in_bl       = bl;
   endtask

   initial begin
      int guard;
      logic [15:0] fin_before;
      logic [5:0] st;
      bus.in_valid = 0;
      bus.out_ready = 0;
      drive_tok('0, '0, '0, '0);
      step();
      chk_on = 1;
      chk("reset_in_flight", bus.in_flight, 0);
      chk("reset_fin_count", bus.fin_count, 0);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_out_read_num", bus.out_read_num, 0);
      chk("reset_in_ready", bus.in_ready, 0);
      step();

      // streaming: five back-to-back tokens
      rst = 1;
      bus.out_ready = 1;
      clear_log();
      for (int i = 1; i <= 5; i++) begin
         drive_tok(RN_W'(i), 6'd0, {$urandom, $urandom}, {$urandom, $urandom});
         bus.in_valid = 1;
         step();
      end
      bus.in_valid = 0;
      repeat (6) step();
      chk("stream_count", outs.size(), 5);
      for (int i = 0; i < outs.size(); i++) chk("stream_order", outs[i], i + 1);
      chk("stream_latency", out_first - hs_first, DEPTH);
      chk("stream_back_to_back", out_last - out_first, 4);

      // backpressure: pipe fills with DEPTH tokens and stops accepting
      clear_log();
      bus.out_ready = 0;
      bus.in_valid = 1;
      repeat (6) begin
         drive_tok(RN_W'(10 + hs_n), 6'd0, {$urandom, $urandom}, {$urandom, $urandom});
         step();
      end
      chk("bp_accepts", hs_n, 3);
      chk("bp_in_flight", bus.in_flight, 3);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_model_size", q.size(), 3);
      bus.in_valid = 0;
      bus.out_ready = 1;
      repeat (6) step();
      chk("bp_drained", outs.size(), 3);
      for (int i = 0; i < outs.size(); i++) chk("bp_order", outs[i], 10 + i);

      // memory request with line address split
      clear_log();
      drive_tok(RN_W'(30), ST_BWD, 64'h0000_1234_5678_9AC0, 64'h0000_1234_5678_9B00);
      bus.in_valid = 1;
      step();
      bus.in_valid = 0;
      repeat (5) step();
      chk("req_count", req_n, 1);
      chk("req_addr_k", req_k, 42'h48D159E26B);
      chk("req_addr_l", req_l, 42'h48D159E26C);

      // stall then flush
      clear_log();
      bus.in_valid = 1;
      drive_tok(RN_W'(20), ST_FIN, {$urandom, $urandom}, {$urandom, $urandom});
      step();
      drive_tok(RN_W'(21), ST_FIN, {$urandom, $urandom}, {$urandom, $urandom});
      step();
      drive_tok(RN_W'(22), ST_FIN, {$urandom, $urandom}, {$urandom, $urandom});
      stall = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("stall_in_flight", bus.in_flight, 2);
         chk("stall_in_ready", bus.in_ready, 0);
         chk("stall_request", bus.request_valid, 0);
         step();
      end
      stall = 0;
      step();
      drive_tok(RN_W'(23), ST_FIN, {$urandom, $urandom}, {$urandom, $urandom});
      step();
      flush = 1;
      fin_before = m_fin;
      chk("flush_fin_moved", fin_before, 16'd1);
      step();
      flush = 0;
      bus.in_valid = 0;
      #1;
      chk("flush_out_valid", bus.out_valid, 0);
      chk("flush_in_flight", bus.in_flight, 0);
      chk("flush_fin_count", bus.fin_count, fin_before);
      chk("flush_model_size", q.size(), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.in_valid  = $urandom_range(0, 3) != 0;
         bus.out_ready = $urandom_range(0, 3) != 0;
         stall = $urandom_range(0, 9) == 0;
         flush = $urandom_range(0, 29) == 0;
         case ($urandom_range(0, 2))
            0: st = ST_BWD;
            1: st = ST_FIN;
            default: st = 6'($urandom);
         endcase
         drive_tok(RN_W'($urandom), st, {$urandom, $urandom}, {$urandom, $urandom});
         step();
      end

      // reset mid-stream, then latency of the first token after release
      stall = 0;
      flush = 0;
      bus.out_ready = 0;
      bus.in_valid = 1;
      drive_tok(RN_W'(5), ST_FIN, {$urandom, $urandom}, {$urandom, $urandom});
      repeat (3) step();
      rst = 0;
      #1;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_finish_sign", bus.finish_sign, 0);
      chk("rst_request", bus.request_valid, 0);
      step();
      chk("rst_mid_in_flight", bus.in_flight, 0);
      chk("rst_mid_out_valid", bus.out_valid, 0);
      chk("rst_mid_fin_count", bus.fin_count, 0);
      rst = 1;
      clear_log();
      bus.out_ready = 1;
      drive_tok(RN_W'(77), 6'd0, {$urandom, $urandom}, {$urandom, $urandom});
      step();
      bus.in_valid = 0;
      repeat (5) step();
      chk("rst_rel_count", outs.size(), 1);
      if (outs.size() > 0) chk("rst_rel_token", outs[0], 77);
      chk("rst_rel_latency", out_first - hs_first, DEPTH);

      // completion counter wrap
      clear_log();
      drive_tok(RN_W'(1), ST_FIN, {$urandom, $urandom}, {$urandom, $urandom});
      bus.in_valid = 1;
      guard = 0;
      while (hs_n < 65535 && guard < 70000) begin
         step();
         guard++;
      end
      bus.in_valid = 0;
      chk("wrap_handshakes", hs_n, 65535);
      outs.delete();
      repeat (5) step();
      chk("wrap_preset", bus.fin_count, 16'hFFFF);
      chk("wrap_model_preset", m_fin, 16'hFFFF);
      fs_seen = 0;
      bus.in_valid = 1;
      step();
      bus.in_valid = 0;
      repeat (5) step();
      chk("wrap_finish_seen", fs_seen, 1);
      chk("wrap_fin_count", bus.fin_count, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
